// File: rtl/decode_stage.sv
// Thumb-subset decode stage: valid/ready in, registered decoded bundle out.
// Define DECODE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module decode_stage #(
  parameter int DW  = 16,
  parameter int RAW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [15:0]    in_instr,
  input  logic [DW-1:0]  in_pc,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RAW-1:0] r_addr1,
  output logic [RAW-1:0] r_addr2,
  output logic [RAW-1:0] w_addr,
  output logic           we,
  output logic [2:0]     alu_op,
  output logic [1:0]     shifter_op,
  output logic [3:0]     mux,
  output logic [DW-1:0]  imm,
  output logic           imm_sel,
  output logic           move,
  output logic           move_const,
  output logic           l_s,
  output logic           branch,
  output logic [DW-1:0]  next_pc,
  output logic           illegal
);

  typedef struct packed {
    logic [RAW-1:0] r_addr1;
    logic [RAW-1:0] r_addr2;
    logic [RAW-1:0] w_addr;
    logic           we;
    logic [2:0]     alu_op;
    logic [1:0]     shifter_op;
    logic [3:0]     mux;
    logic [DW-1:0]  imm;
    logic           imm_sel;
    logic           move;
    logic           move_const;
    logic           l_s;
    logic           branch;
    logic [DW-1:0]  next_pc;
    logic           illegal;
  } bundle_t;

  localparam logic [3:0] MUX_ALU = 4'b0001;
  localparam logic [3:0] MUX_SHF = 4'b0010;
  localparam logic [3:0] MUX_IMM = 4'b0100;

  function automatic logic [RAW-1:0] reg3(input logic [2:0] f);
    return {{(RAW-3){1'b0}}, f};
  endfunction

  logic          is_addsub_r;
  logic          is_addsub_i;
  logic          is_movs;
  logic          is_alu;
  logic          is_bcond;
  logic          is_b;
  logic          is_nop;
  logic [DW-1:0] sext8;
  logic [DW-1:0] sext11;
  logic [DW-1:0] pc_inc;
  bundle_t       dec;

  assign is_addsub_r = in_instr[15:10] == 6'b000110;
  assign is_addsub_i = in_instr[15:10] == 6'b000111;
  assign is_movs     = in_instr[15:11] == 5'b00100;
  assign is_alu      = in_instr[15:10] == 6'b010000;
  assign is_bcond    = in_instr[15:12] == 4'b1101
                    && in_instr[11:9] != 3'b111;
  assign is_b        = in_instr[15:11] == 5'b11100;
  assign is_nop      = in_instr == 16'hBF00;

  assign sext8  = {{(DW-8){in_instr[7]}}, in_instr[7:0]};
  assign sext11 = {{(DW-11){in_instr[10]}}, in_instr[10:0]};
  assign pc_inc = in_pc + DW'(1);

  always_comb begin
    dec         = '0;
    dec.next_pc = pc_inc;
    unique case (1'b1)
      is_addsub_r: begin
        dec.r_addr1 = reg3(in_instr[5:3]);
        dec.r_addr2 = reg3(in_instr[8:6]);
        dec.w_addr  = reg3(in_instr[2:0]);
        dec.we      = 1'b1;
        dec.alu_op  = in_instr[9] ? 3'b010 : 3'b001;
        dec.mux     = MUX_ALU;
      end
      is_addsub_i: begin
        dec.r_addr1 = reg3(in_instr[5:3]);
        dec.w_addr  = reg3(in_instr[2:0]);
        dec.we      = 1'b1;
        dec.alu_op  = in_instr[9] ? 3'b010 : 3'b001;
        dec.imm     = {{(DW-3){1'b0}}, in_instr[8:6]};
        dec.imm_sel = 1'b1;
        dec.mux     = MUX_ALU;
      end
      is_movs: begin
        dec.w_addr     = reg3(in_instr[10:8]);
        dec.imm        = {{(DW-8){1'b0}}, in_instr[7:0]};
        dec.move_const = 1'b1;
        dec.we         = 1'b1;
        dec.mux        = MUX_IMM;
      end
      is_alu: begin
        dec.r_addr1 = reg3(in_instr[2:0]);
        dec.r_addr2 = reg3(in_instr[5:3]);
        dec.w_addr  = reg3(in_instr[2:0]);
        dec.we      = 1'b1;
        dec.mux     = MUX_ALU;
        // op field follows the Thumb data-processing numbering
        case (in_instr[9:6])
          4'b0000: dec.alu_op = 3'b011;
          4'b0001: dec.alu_op = 3'b100;
          4'b1100: dec.alu_op = 3'b101;
          4'b1111: dec.alu_op = 3'b110;
          4'b1010: begin
            dec.alu_op = 3'b111;
            dec.we     = 1'b0;
          end
          4'b0010: begin
            dec.shifter_op = 2'b00;
            dec.mux        = MUX_SHF;
          end
          4'b0011: begin
            dec.shifter_op = 2'b01;
            dec.mux        = MUX_SHF;
          end
          4'b0100: begin
            dec.shifter_op = 2'b10;
            dec.mux        = MUX_SHF;
          end
          4'b0111: begin
            dec.shifter_op = 2'b11;
            dec.mux        = MUX_SHF;
          end
          default: begin
            dec         = '0;
            dec.next_pc = pc_inc;
            dec.illegal = 1'b1;
          end
        endcase
      end
      is_bcond: begin
        dec.branch  = 1'b1;
        dec.imm     = sext8;
        dec.next_pc = pc_inc + sext8;
      end
      is_b: begin
        dec.branch  = 1'b1;
        dec.imm     = sext11;
        dec.next_pc = pc_inc + sext11;
      end
      is_nop: begin
        dec.illegal = 1'b0;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  bundle_t out_q;
  bundle_t out_d;
  logic    out_valid_q;
  logic    out_valid_d;
  logic    accept;

  assign accept = in_valid && in_ready && !flush;

`ifdef DECODE_SKID_EN
  bundle_t skid_q;
  bundle_t skid_d;
  logic    skid_valid_q;
  logic    skid_valid_d;

  assign in_ready = !skid_valid_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_ready) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      // stalled output: park the new bundle behind it
      if (out_valid_q && !out_ready) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end else begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign r_addr1    = out_q.r_addr1;
  assign r_addr2    = out_q.r_addr2;
  assign w_addr     = out_q.w_addr;
  assign we         = out_q.we;
  assign alu_op     = out_q.alu_op;
  assign shifter_op = out_q.shifter_op;
  assign mux        = out_q.mux;
  assign imm        = out_q.imm;
  assign imm_sel    = out_q.imm_sel;
  assign move       = out_q.move;
  assign move_const = out_q.move_const;
  assign l_s        = out_q.l_s;
  assign branch     = out_q.branch;
  assign next_pc    = out_q.next_pc;
  assign illegal    = out_q.illegal;

endmodule
